fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch front end sitting directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into instruction memory, which is combinational and word-indexed internally.
- Captures the returned instruction into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Handles stall, branch/jump redirect with flush, and halt.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and address buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_WIDTH, 10, instruction memory word-index width; used only for the optional fault check.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  DATA_WIDTH  byte address to instruction memory; equals pc register.
- imem_instr  input  DATA_WIDTH  instruction returned combinationally for imem_addr.
- stall  input  1  hazard stall; blocks new fetches.
- redirect  input  1  taken branch/jump; flush and load new PC.
- redirect_pc  input  DATA_WIDTH  redirect target byte address.
- halt  input  1  stop fetching until next redirect.
- id_ready  input  1  decode accepts if_instr this cycle.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_pc  output  DATA_WIDTH  PC of the held instruction.
- if_instr  output  DATA_WIDTH  held instruction word.
- if_pc_plus4  output  DATA_WIDTH  if_pc + 4, modulo 2^DATA_WIDTH.
- fetch_count  output  32  number of instructions loaded into IF/ID since reset; wraps.
- halted  output  1  high in HALTED state.

Behaviour:
- Reset (async assert, sync-released use):
  - pc = RESET_PC; state = BOOT.
  - if_valid = 0; if_pc, if_instr, if_pc_plus4, fetch_count = 0; halted = 0.
- States:
  - BOOT: one cycle, no fetch; goes to RUN unconditionally, or to HALTED if halt is high.
  - RUN: normal fetching.
  - HALTED: no fetch, pc frozen, halted = 1; leaves only on redirect (to RUN).
- Definitions:
  - consume = if_valid & id_ready.
  - slot_free = !if_valid | id_ready.
  - fetch = (state == RUN) & !stall & !halt & !redirect & slot_free.
- Priority per cycle: redirect > halt > stall > normal.
- On fetch:
  - if_valid <= 1, if_pc <= pc, if_instr <= imem_instr, if_pc_plus4 <= pc + 4.
  - pc <= pc + 4; fetch_count += 1.
- On redirect, in any state except BOOT:
  - pc <= redirect_pc; if_valid <= 0, dropping the held instruction even if id_ready is high that cycle.
  - state <= RUN.
  - First fetch from the target occurs the following cycle; redirect-to-fetch latency is 1 cycle.
- Redirect in BOOT: pc is loaded, state goes to RUN.
- On halt in RUN without redirect:
  - state <= HALTED; no fetch this cycle.
  - An already-valid instruction stays until consumed; consume clears if_valid.
- No fetch and consume: if_valid <= 0, other IF/ID fields hold.
- No fetch and no consume: all IF/ID fields hold stable. Decode may rely on if_instr not changing while if_valid & !id_ready.
- Throughput: 1 instruction/cycle while id_ready stays high and there is no stall.
- Arithmetic: pc + 4 wraps, so 32'hFFFF_FFFC → 32'h0000_0000. Low 2 bits of pc are passed through unchanged.
- imem_addr is a registered output (the pc register), glitch-free.
- Reset asserted mid-operation: all state returns to reset values immediately; any held instruction is lost.

Optional Feature:
- FETCH_FAULT_CHK_EN:
  - When defined, adds output if_fault (1 bit, registered alongside the IF/ID fields).
  - if_fault is set when the fetched pc has pc[1:0] != 0 or any of pc[DATA_WIDTH-1:ADDR_WIDTH+2] set, i.e. misaligned or outside instruction memory.
  - A fault fetch still loads IF/ID, but pc is not advanced and state goes to HALTED.
  - Reset value is 0.
- When undefined: no if_fault port; misaligned or out-of-range PCs fetch the aliased word silently.

Test Plan:
- Reset release with RESET_PC=0 and memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193, id_ready=1 → cycle after BOOT:
  - if_valid=1, if_pc=0, if_instr=0x00000013.
  - Next cycles: if_pc=4, 8, 12 with matching words; fetch_count=3 after third fetch.
- id_ready=0 for 3 cycles while if_valid=1 → if_pc/if_instr unchanged, pc unchanged, fetch_count unchanged. Raising id_ready resumes at 1 instruction/cycle.
- stall=1 with id_ready=1 → held instruction consumed, if_valid=0 next cycle, pc frozen. Releasing stall fetches the next sequential PC.
- redirect=1, redirect_pc=0x40, with if_valid=1 and id_ready=1 → next cycle if_valid=0; the cycle after: if_pc=0x40, if_pc_plus4=0x44.
- halt=1 in RUN → halted=1, no further fetches for 5 cycles. Then redirect to 0x8 → halted=0, next fetch at if_pc=0x8.
- pc=0xFFFF_FFFC fetch → if_pc_plus4=0, next if_pc=0.
- With FETCH_FAULT_CHK_EN: redirect_pc=0x6 → fetch gives if_fault=1 and state HALTED.
- With FETCH_FAULT_CHK_EN, ADDR_WIDTH=10: redirect_pc=0x1000 → if_fault=1.
- Reset asserted mid-run → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Instruction-fetch front end: program counter, IF/ID register with
//            valid/ready toward decode, stall, redirect/flush and halt.
//            Define FETCH_FAULT_CHK_EN to add the if_fault output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}},
   parameter int                    ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_instr,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  halt,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [DATA_WIDTH-1:0] if_pc_plus4,
   output logic [31:0]           fetch_count,
   output logic                  halted
`ifdef FETCH_FAULT_CHK_EN
   ,
   output logic                  if_fault
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);

   // The out-of-range slice below needs at least one address bit above the word index.
   generate
      if (ADDR_WIDTH + 2 >= DATA_WIDTH) begin : g_addr_width_check
         $error("fetch_pc_unit: ADDR_WIDTH + 2 must be below DATA_WIDTH");
      end
   endgenerate

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] w_pc_nxt;
   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic                  r_if_valid;
   logic [DATA_WIDTH-1:0] r_if_pc;
   logic [DATA_WIDTH-1:0] r_if_instr;
   logic [DATA_WIDTH-1:0] r_if_pc_plus4;
   logic [31:0]           r_fetch_count;
   logic                  w_consume;
   logic                  w_slot_free;
   logic                  w_fetch;
   logic                  w_fault;

   assign w_pc_plus4  = r_pc + c_pc_step;
   assign w_consume   = r_if_valid & id_ready;
   assign w_slot_free = ~r_if_valid | id_ready;
   assign w_fetch     = (r_state == ST_RUN) & ~stall & ~halt & ~redirect & w_slot_free;

`ifdef FETCH_FAULT_CHK_EN
   assign w_fault = (r_pc[1:0] != 2'b00) | (|r_pc[DATA_WIDTH-1:ADDR_WIDTH+2]);
`else
   assign w_fault = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (redirect) begin
         w_state_nxt = ST_RUN;
         w_pc_nxt    = redirect_pc;
      end else begin
         case (r_state)
            ST_BOOT: w_state_nxt = halt ? ST_HALTED : ST_RUN;
            ST_RUN: begin
               if (halt) begin
                  w_state_nxt = ST_HALTED;
               end else if (w_fetch) begin
                  // A faulting fetch parks the pc on the bad address for debug.
                  if (w_fault) w_state_nxt = ST_HALTED;
                  else         w_pc_nxt    = w_pc_plus4;
               end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_pc       <= '0;
         r_if_instr    <= '0;
         r_if_pc_plus4 <= '0;
         r_fetch_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         // A redirect drops the held word even when decode is ready this cycle.
         if (redirect) begin
            r_if_valid <= 1'b0;
         end else if (w_fetch) begin
            r_if_valid    <= 1'b1;
            r_if_pc       <= r_pc;
            r_if_instr    <= imem_instr;
            r_if_pc_plus4 <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + 32'd1;
         end else if (w_consume) begin
            r_if_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_FAULT_CHK_EN
   logic r_if_fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_if_fault <= 1'b0;
      else if (w_fetch) r_if_fault <= w_fault;
   end

   assign if_fault = r_if_fault;
`endif

   assign imem_addr   = r_pc;
   assign if_valid    = r_if_valid;
   assign if_pc       = r_if_pc;
   assign if_instr    = r_if_instr;
   assign if_pc_plus4 = r_if_pc_plus4;
   assign fetch_count = r_fetch_count;
   assign halted      = (r_state == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Self-checking bench for fetch_pc_unit with a word-indexed
//            instruction memory model and an in-order consume scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] if_pc_plus4;
   logic [31:0] fetch_count;
   logic        halted;
`ifdef FETCH_FAULT_CHK_EN
   logic        if_fault;
`endif

   logic [31:0] mem [0:1023];
   logic [31:0] sb_q [$];
   int          checks = 0;
   int          errors = 0;

   fetch_pc_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .ADDR_WIDTH (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .id_ready    (id_ready),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_pc_plus4 (if_pc_plus4),
      .fetch_count (fetch_count),
      .halted      (halted)
`ifdef FETCH_FAULT_CHK_EN
      ,
      .if_fault    (if_fault)
`endif
   );

   assign imem_instr = mem[imem_addr[11:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every instruction decode actually accepts must match the next expected pc.
   always @(negedge clk) begin
      logic [31:0] exp_pc;
      if (rst_n && if_valid && id_ready && !redirect) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pc %h, expected no instruction", if_pc);
         end else begin
            exp_pc = sb_q.pop_front();
            if (if_pc !== exp_pc || if_instr !== mem[exp_pc[11:2]] ||
                if_pc_plus4 !== exp_pc + 32'd4) begin
               errors++;
               $display("FAIL sb_consume: got pc %h instr %h plus4 %h, expected pc %h instr %h plus4 %h",
                        if_pc, if_instr, if_pc_plus4, exp_pc, mem[exp_pc[11:2]], exp_pc + 32'd4);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      halt = 1'b0; id_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (if_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
      checks++; if (if_pc !== 32'h0)     begin errors++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
      checks++; if (if_instr !== 32'h0)  begin errors++; $display("FAIL rst_if_instr: got %h expected 0", if_instr); end
      checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_plus4: got %h expected 0", if_pc_plus4); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fetch_count); end
      checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
      tick(); tick();
      rst_n = 1'b1;
      sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_nofetch: got %b expected 0", if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0000_0013) begin
         errors++; $display("FAIL first_fetch: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=00000013", if_valid, if_pc, if_instr);
      end
      tick(); tick();
      checks++; if (if_pc !== 32'h8 || fetch_count !== 32'd3 || imem_addr !== 32'hC) begin
         errors++; $display("FAIL third_fetch: got pc=%h count=%0d addr=%h expected pc=8 count=3 addr=c", if_pc, fetch_count, imem_addr);
      end
   endtask

   task automatic test_backpressure();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2] ||
                       fetch_count !== 32'd3 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL bp_hold: got v=%b pc=%h instr=%h count=%0d addr=%h expected v=1 pc=8 instr=%h count=3 addr=c",
                               if_valid, if_pc, if_instr, fetch_count, imem_addr, mem[2]);
         end
      end
      sb_q.push_back(32'h8); // still held, counted once more below via the queue head
      void'(sb_q.pop_back());
      sb_q.push_back(32'hC); sb_q.push_back(32'h10); sb_q.push_back(32'h14);
      id_ready = 1'b1;
      tick();
      checks++; if (if_pc !== 32'hC) begin errors++; $display("FAIL bp_resume: got pc=%h expected c", if_pc); end
      tick(); tick();
      checks++; if (if_pc !== 32'h14 || fetch_count !== 32'd6) begin
         errors++; $display("FAIL bp_rate: got pc=%h count=%0d expected pc=14 count=6", if_pc, fetch_count);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      tick();
      checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h18) begin
         errors++; $display("FAIL stall_drain: got v=%b addr=%h expected v=0 addr=18", if_valid, imem_addr);
      end
      tick();
      checks++; if (imem_addr !== 32'h18 || fetch_count !== 32'd6) begin
         errors++; $display("FAIL stall_freeze: got addr=%h count=%0d expected addr=18 count=6", imem_addr, fetch_count);
      end
      stall = 1'b0;
      sb_q.push_back(32'h18);
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h18) begin
         errors++; $display("FAIL stall_release: got v=%b pc=%h expected v=1 pc=18", if_valid, if_pc);
      end
   endtask

   task automatic test_redirect();
      tick(); // 0x18 consumed, 0x1C fetched and then flushed
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h40) begin
         errors++; $display("FAIL redir_flush: got v=%b addr=%h expected v=0 addr=40", if_valid, imem_addr);
      end
      sb_q.push_back(32'h40);
      tick();
      checks++; if (if_pc !== 32'h40 || if_pc_plus4 !== 32'h44 || if_instr !== mem[16]) begin
         errors++; $display("FAIL redir_target: got pc=%h plus4=%h instr=%h expected pc=40 plus4=44 instr=%h",
                            if_pc, if_pc_plus4, if_instr, mem[16]);
      end
   endtask

   task automatic test_halt();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++; if (halted !== 1'b1 || if_valid !== 1'b0) begin
         errors++; $display("FAIL halt_enter: got halted=%b v=%b expected halted=1 v=0", halted, if_valid);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (halted !== 1'b1 || fetch_count !== 32'd9 || imem_addr !== 32'h44 || if_valid !== 1'b0) begin
            errors++; $display("FAIL halt_idle: got halted=%b count=%0d addr=%h v=%b expected halted=1 count=9 addr=44 v=0",
                               halted, fetch_count, imem_addr, if_valid);
         end
      end
      redirect = 1'b1; redirect_pc = 32'h8;
      tick();
      redirect = 1'b0;
      checks++; if (halted !== 1'b0 || imem_addr !== 32'h8) begin
         errors++; $display("FAIL halt_exit: got halted=%b addr=%h expected halted=0 addr=8", halted, imem_addr);
      end
      sb_q.push_back(32'h8);
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2]) begin
         errors++; $display("FAIL halt_refetch: got v=%b pc=%h instr=%h expected v=1 pc=8 instr=%h", if_valid, if_pc, if_instr, mem[2]);
      end
   endtask

   task automatic test_wrap();
      tick(); // 0x8 consumed, 0xC fetched and then flushed
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      sb_q.push_back(32'hFFFF_FFFC); sb_q.push_back(32'h0);
      tick();
      checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || if_instr !== mem[1023]) begin
         errors++; $display("FAIL wrap_top: got pc=%h plus4=%h addr=%h instr=%h expected pc=fffffffc plus4=0 addr=0 instr=%h",
                            if_pc, if_pc_plus4, imem_addr, if_instr, mem[1023]);
      end
      tick();
      checks++; if (if_pc !== 32'h0 || if_instr !== mem[0] || fetch_count !== 32'd13) begin
         errors++; $display("FAIL wrap_next: got pc=%h instr=%h count=%0d expected pc=0 instr=%h count=13", if_pc, if_instr, fetch_count, mem[0]);
      end
   endtask

`ifdef FETCH_FAULT_CHK_EN
   task automatic test_fault();
      tick();
      redirect = 1'b1; redirect_pc = 32'h6;
      tick();
      redirect = 1'b0;
      sb_q.push_back(32'h6);
      tick();
      checks++; if (if_fault !== 1'b1 || halted !== 1'b1 || imem_addr !== 32'h6) begin
         errors++; $display("FAIL fault_misalign: got fault=%b halted=%b addr=%h expected fault=1 halted=1 addr=6", if_fault, halted, imem_addr);
      end
      redirect = 1'b1; redirect_pc = 32'h1000;
      tick();
      redirect = 1'b0;
      sb_q.push_back(32'h1000);
      tick();
      checks++; if (if_fault !== 1'b1 || if_pc !== 32'h1000 || halted !== 1'b1) begin
         errors++; $display("FAIL fault_range: got fault=%b pc=%h halted=%b expected fault=1 pc=1000 halted=1", if_fault, if_pc, halted);
      end
   endtask
`endif

   task automatic test_mid_reset();
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0 ||
                    fetch_count !== 32'h0 || halted !== 1'b0 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL mid_reset: got v=%b pc=%h instr=%h plus4=%h count=%0d halted=%b addr=%h expected all zero",
                            if_valid, if_pc, if_instr, if_pc_plus4, fetch_count, halted, imem_addr);
      end
      tick();
      rst_n = 1'b1;
      tick(); tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || fetch_count !== 32'd1) begin
         errors++; $display("FAIL post_reset: got v=%b pc=%h count=%0d expected v=1 pc=0 count=1", if_valid, if_pc, fetch_count);
      end
      id_ready = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 7);
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113;
      mem[3] = 32'h0030_0193;
      test_reset();
      test_backpressure();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
`ifdef FETCH_FAULT_CHK_EN
      test_fault();
`endif
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
